// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule feeding an inverse cipher: expands one round key per cycle, then
// serves them from round 10 down to round 0. Optional macro: AES_KEY_SCHED_ZEROIZE_EN.
module aes_inv_key_sched #(
  parameter int WRAP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         rk_next,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy,
  output logic         keys_ready,
  output logic [1:0]   fsm_state
);

  // Handshake: key_load is a single-cycle request, honoured only outside EXPAND.
  // rk_next is a single-cycle advance, honoured only in READY; key_load wins over it.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [127:0] mem [0:10];
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  sub_rot;
  logic [7:0]   rcon;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = xtime(aa);
    end
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign prev_idx = cnt - 4'd1;
  assign prev_key = mem[prev_idx];

  // RotWord then SubWord on the last word of the previous round key, plus rcon.
  assign sub_rot = {sbox(prev_key[23:16]) ^ rcon, sbox(prev_key[15:8]),
                    sbox(prev_key[7:0]), sbox(prev_key[31:24])};

  always_comb begin
    next_key = '0;
    next_key[127:96] = prev_key[127:96] ^ sub_rot;
    next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
    next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
    next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      rk_idx     <= 4'd0;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      for (int i = 0; i <= 10; i++) mem[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (key_load) begin
            mem[0]     <= key_in;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
            for (int i = 1; i <= 10; i++) mem[i] <= '0;
`endif
            cnt        <= 4'd1;
            rk_idx     <= 4'd10;
            state      <= ST_EXPAND;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
          end else if (state == ST_READY && rk_next) begin
            if (rk_idx != 4'd0) rk_idx <= rk_idx - 4'd1;
            else if (WRAP != 0) rk_idx <= 4'd10;
          end
        end
        ST_EXPAND: begin
          mem[cnt] <= next_key;
          cnt      <= cnt + 4'd1;
          if (cnt == 4'd10) begin
            state      <= ST_READY;
            busy       <= 1'b0;
            keys_ready <= 1'b1;
            rk_idx     <= 4'd10;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign round_key = keys_ready ? mem[rk_idx] : '0;
`else
  assign round_key = mem[rk_idx];
`endif

  assign rk_last   = keys_ready && (rk_idx == 4'd0);
  assign fsm_state = state;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 word-level key expansion model, per-cycle
// scoreboard compare, and directed scenarios with literal round keys.
module tb_aes_inv_key_sched;
  localparam int WRAP = 1;
  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_next = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;
  logic         keys_ready;
  logic [1:0]   fsm_state;

  int checks = 0;
  int failures = 0;

  aes_inv_key_sched #(.WRAP(WRAP)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .rk_next(rk_next),
    .round_key(round_key), .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy),
    .keys_ready(keys_ready), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // reference model: polynomial GF(2^8) arithmetic and FIPS-197 word recurrence
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] ref_rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])}
            ^ {ref_rcon(i / 4), 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // model state: visible key store, pending schedule, expansion steps left, index
  logic [127:0] m_mem [11];
  logic [127:0] m_sched [11];
  int           m_left = 0;
  int           m_idx = 0;
  bit           m_ready = 1'b0;
  logic [127:0] exp_q [$];

  function automatic logic [127:0] model_round_key();
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    return m_ready ? m_mem[m_idx] : 128'h0;
`else
    return m_mem[m_idx];
`endif
  endfunction

  initial for (int i = 0; i < 11; i++) m_mem[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) m_mem[i] = '0;
      m_left  = 0;
      m_idx   = 0;
      m_ready = 1'b0;
    end else if (m_left > 0) begin
      m_mem[11 - m_left] = m_sched[11 - m_left];
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        m_idx   = 10;
      end
    end else if (key_load) begin
      for (int r = 0; r < 11; r++) m_sched[r] = ref_round_key(key_in, r);
      m_mem[0] = key_in;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
      for (int i = 1; i < 11; i++) m_mem[i] = '0;
`endif
      m_left  = 10;
      m_ready = 1'b0;
      m_idx   = 10;
    end else if (m_ready && rk_next) begin
      if (m_idx > 0) m_idx = m_idx - 1;
      else m_idx = (WRAP != 0) ? 10 : 0;
    end
    exp_q.delete();
    exp_q.push_back(model_round_key());
  end

  // scoreboard: every falling edge compares the DUT with the model
  always @(negedge clk) begin
    logic [127:0] exp_key;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_queue got=empty exp=entry");
    end else begin
      exp_key = exp_q.pop_front();
      check("sb_round_key", round_key, exp_key);
    end
    check("sb_busy", 128'(busy), 128'(m_left > 0));
    check("sb_keys_ready", 128'(keys_ready), 128'(m_ready));
    check("sb_rk_idx", 128'(rk_idx), 128'(m_idx));
    check("sb_rk_last", 128'(rk_last), 128'(m_ready && m_idx == 0));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
    key_in   = '0;
  endtask

  task automatic pulse_next(input int n);
    rk_next = 1'b1;
    repeat (n) tick();
    rk_next = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    check("rst_rk_last", 128'(rk_last), 128'(0));
    check("rst_round_key", round_key, 128'h0);
    check("model_sbox_00", 128'(ref_sbox(8'h00)), 128'h63);
    check("model_sbox_53", 128'(ref_sbox(8'h53)), 128'hed);
    repeat (2) tick();
    rst_n = 1'b1;

    // basic expansion and readiness timing
    load_key(K1);
    check("exp_busy", 128'(busy), 128'(1));
    check("exp_rk_idx", 128'(rk_idx), 128'(10));
    repeat (9) tick();
    check("ready_not_yet", 128'(keys_ready), 128'(0));
    tick();
    check("ready_rise", 128'(keys_ready), 128'(1));
    check("ready_busy_low", 128'(busy), 128'(0));
    check("ready_rk_idx", 128'(rk_idx), 128'(10));
    check("k1_round10", round_key, K1_R10);

    // walk down to round 0
    pulse_next(9);
    check("walk_rk_idx1", 128'(rk_idx), 128'(1));
    check("k1_round1", round_key, K1_R1);
    pulse_next(1);
    check("walk_rk_idx0", 128'(rk_idx), 128'(0));
    check("walk_rk_last", 128'(rk_last), 128'(1));
    check("k1_round0", round_key, K1);
    pulse_next(1);
    check("wrap_rk_idx", 128'(rk_idx), (WRAP != 0) ? 128'(10) : 128'(0));
    check("wrap_rk_last", 128'(rk_last), (WRAP != 0) ? 128'(0) : 128'(1));

    // key_load during expansion is ignored
    load_key(K1);
    repeat (3) tick();
    load_key(K2);
    repeat (5) tick();
    check("ignore_not_ready", 128'(keys_ready), 128'(0));
    tick();
    check("ignore_ready", 128'(keys_ready), 128'(1));
    check("ignore_round10", round_key, K1_R10);

    // key_load beats rk_next in READY
    rk_next  = 1'b1;
    key_load = 1'b1;
    key_in   = K2;
    tick();
    rk_next  = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    check("prio_busy", 128'(busy), 128'(1));
    check("prio_rk_idx", 128'(rk_idx), 128'(10));
    check("prio_keys_ready", 128'(keys_ready), 128'(0));
    repeat (10) tick();
    check("k2_round10", round_key, K2_R10);

    // reset in the middle of expansion
    load_key(K1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_keys_ready", 128'(keys_ready), 128'(0));
    check("midrst_round_key", round_key, 128'h0);
    check("midrst_rk_idx", 128'(rk_idx), 128'(0));
    #2 rst_n = 1'b1;
    load_key(K2);
    repeat (10) tick();
    check("post_rst_ready", 128'(keys_ready), 128'(1));
    check("post_rst_round10", round_key, K2_R10);
    pulse_next(10);
    check("post_rst_round0", round_key, K2);
    check("post_rst_rk_last", 128'(rk_last), 128'(1));
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
